// File: rtl/lenet_pkg.sv
// Shared LeNet pipeline definitions: arithmetic selectors, pooling FSM states,
// debug view of the pooling stage and the window max comparator.
package lenet_pkg;

  localparam logic ARITH_FIXED = 1'b1;
  localparam logic ARITH_FLOAT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_NEXT,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } pool_state_t;

  typedef struct packed {
    pool_state_t state;
    logic [1:0]  next_free;
    logic [2:0]  channel;
    logic        pending;
  } pool_dbg_t;

  // Returns the larger of acc and word (low `width` bits used); a tie keeps acc.
  // Float words are ordered as sign-magnitude values, so +0 and -0 tie.
  function automatic logic [63:0] pool_max(input logic [63:0] acc,
                                           input logic [63:0] word,
                                           input int width,
                                           input logic arith);
    logic signed [63:0] acc_s;
    logic signed [63:0] word_s;
    logic [63:0] mag_mask;
    logic [63:0] acc_mag;
    logic [63:0] word_mag;
    logic acc_neg;
    logic word_neg;
    logic take;
    acc_s    = signed'(acc << (64 - width));
    word_s   = signed'(word << (64 - width));
    mag_mask = (64'd1 << (width - 1)) - 64'd1;
    acc_mag  = acc & mag_mask;
    word_mag = word & mag_mask;
    acc_neg  = acc[width-1];
    word_neg = word[width-1];
    if (arith == ARITH_FIXED)                  take = word_s > acc_s;
    else if (acc_mag == 0 && word_mag == 0)    take = 1'b0;
    else if (acc_neg != word_neg)              take = !word_neg;
    else if (!word_neg)                        take = word_mag > acc_mag;
    else                                       take = word_mag < acc_mag;
    return take ? word : acc;
  endfunction

endpackage

// File: rtl/pool_a2_pingpong_ram.sv
// Two-bank feature-map buffer: the write side fills one bank while the
// pooling side reads the other through a registered read port.
module pool_a2_pingpong_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 784,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_bank,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/pool_a2.sv
// 2x2 stride-2 max-pooling stage: buffers each conv map in a ping-pong RAM,
// then streams one pooled word per window into the next stage's IFM memory.
module pool_a2
  import lenet_pkg::*;
#(
  parameter int ARITH_TYPE            = 1,
  parameter int DATA_WIDTH            = 32,
  parameter int IFM_SIZE              = 28,
  parameter int NUMBER_OF_CHANNELS    = 6,
  parameter int POOL_SIZE             = 2,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE / POOL_SIZE,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(NUMBER_OF_CHANNELS * IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            data_in_from_previous,
  input  logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_write_previous,
  input  logic                             ifm_enable_write_previous,
  input  logic                             ifm_sel_previous,
  input  logic                             start_from_previous,
  output logic                             end_to_previous,
  input  logic                             end_from_next,
  output logic [DATA_WIDTH-1:0]            data_out_for_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic                             ifm_enable_write_next,
  output logic                             start_to_next,
  output logic                             ifm_sel_next,
  output logic                             ready,
  output pool_dbg_t                        dbg
);

  localparam int RW      = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam int KW      = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int CW      = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1;
  localparam int OUT_MAP = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam int OW      = $clog2(OUT_MAP);
  localparam logic ARITH_BIT = (ARITH_TYPE != 0) ? ARITH_FIXED : ARITH_FLOAT;

  // Handshake: start_* and end_* are single-cycle pulses. A start marks the
  // named bank as complete; end_to_previous frees the bank just pooled;
  // end_from_next returns one downstream bank; start_to_next hands over a volume.
  pool_state_t state;
  logic pending, pend_bank, bank, drain_cnt;
  logic [1:0] next_free;
  logic [CW-1:0] channel;
  logic [RW-1:0] row, col;
  logic [KW-1:0] ky, kx;
  logic [OW-1:0] out_idx;
  logic rd_valid, rd_first, rd_last;
  logic [DATA_WIDTH-1:0] rd_data, max_reg, max_next, win_value;
  logic [ADDRESS_SIZE_IFM-1:0] rd_addr;
  logic reading, win_first, win_last, map_last, vol_last, consume;

  assign reading   = state == ST_READ;
  assign win_first = ky == '0 && kx == '0;
  assign win_last  = ky == KW'(POOL_SIZE - 1) && kx == KW'(POOL_SIZE - 1);
  assign map_last  = win_last && row == RW'(IFM_SIZE_NEXT - 1) && col == RW'(IFM_SIZE_NEXT - 1);
  assign vol_last  = channel == CW'(NUMBER_OF_CHANNELS - 1);
  assign consume   = state == ST_IDLE && pending;
  assign rd_addr   = ADDRESS_SIZE_IFM'((POOL_SIZE * int'(row) + int'(ky)) * IFM_SIZE
                                       + POOL_SIZE * int'(col) + int'(kx));

  assign end_to_previous = state == ST_DONE;
  assign start_to_next   = state == ST_DONE && vol_last;
  assign ready           = state == ST_IDLE && !pending;

  assign max_next  = DATA_WIDTH'(pool_max(64'(max_reg), 64'(rd_data), DATA_WIDTH, ARITH_BIT));
  assign win_value = rd_first ? rd_data : max_next;

  assign dbg.state     = state;
  assign dbg.next_free = next_free;
  assign dbg.channel   = 3'(channel);
  assign dbg.pending   = pending;

  pool_a2_pingpong_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IFM_SIZE * IFM_SIZE),
    .AW        (ADDRESS_SIZE_IFM)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ifm_enable_write_previous),
    .wr_bank(ifm_sel_previous),
    .wr_addr(ifm_address_write_previous),
    .wr_data(data_in_from_previous),
    .rd_bank(bank),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      bank <= 1'b0;
      channel <= '0;
      row <= '0;
      col <= '0;
      ky <= '0;
      kx <= '0;
      drain_cnt <= 1'b0;
      ifm_sel_next <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (pending) begin
          bank <= pend_bank;
          row <= '0;
          col <= '0;
          ky <= '0;
          kx <= '0;
          state <= (channel == '0) ? ST_WAIT_NEXT : ST_READ;
        end
        ST_WAIT_NEXT: if (next_free != 2'd0) state <= ST_READ;
        ST_READ: begin
          if (kx == KW'(POOL_SIZE - 1)) begin
            kx <= '0;
            if (ky == KW'(POOL_SIZE - 1)) begin
              ky <= '0;
              if (col == RW'(IFM_SIZE_NEXT - 1)) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              ky <= ky + 1'b1;
            end
          end else begin
            kx <= kx + 1'b1;
          end
          if (map_last) begin
            drain_cnt <= 1'b0;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= ST_DONE;
        end
        ST_DONE: begin
          channel <= vol_last ? '0 : channel + 1'b1;
          if (vol_last) ifm_sel_next <= ~ifm_sel_next;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The slot frees as IDLE consumes it, so a start seen while busy is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      pend_bank <= 1'b0;
    end else if (start_from_previous && (!pending || consume)) begin
      pending <= 1'b1;
      pend_bank <= ifm_sel_previous;
    end else if (consume) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_free <= 2'd2;
    end else if (end_from_next && !start_to_next && next_free != 2'd2) begin
      next_free <= next_free + 2'd1;
    end else if (start_to_next && !end_from_next) begin
      next_free <= next_free - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      rd_last <= 1'b0;
      max_reg <= '0;
      out_idx <= '0;
      ifm_enable_write_next <= 1'b0;
      data_out_for_next <= '0;
      ifm_address_write_next <= '0;
    end else begin
      rd_valid <= reading;
      rd_first <= win_first;
      rd_last <= win_last;
      if (rd_valid) max_reg <= win_value;
      ifm_enable_write_next <= rd_valid && rd_last;
      if (state == ST_IDLE) out_idx <= '0;
      if (rd_valid && rd_last) begin
        data_out_for_next <= win_value;
        ifm_address_write_next <= ADDRESS_SIZE_NEXT_IFM'(int'(channel) * OUT_MAP + int'(out_idx));
        out_idx <= out_idx + 1'b1;
      end
    end
  end

endmodule
